// File: rtl/bpred_pkg.sv
// Shared definitions for the branch-predictor pattern-table scheduler.
// Holds the 2-bit counter encodings, the scheduler state enum and the
// saturating-counter update function used on read-modify-write.
package bpred_pkg;

    localparam logic [1:0] SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] WNT = 2'b01;  // weakly not taken
    localparam logic [1:0] WT  = 2'b10;  // weakly taken
    localparam logic [1:0] ST  = 2'b11;  // strongly taken

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_UPD_WR = 2'd2
    } sched_state_e;

    // 2-bit saturating counter step toward the resolved outcome.
    function automatic logic [1:0] sat(input logic [1:0] v, input logic taken);
        logic [1:0] r;
        if (taken) begin
            r = (v == ST) ? ST : v + 2'd1;
        end else begin
            r = (v == SNT) ? SNT : v - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bpred_table_sched_if.sv
// Bus bundle between the pattern-table scheduler and its neighbours.
// Groups the fetch lookup port (lk_*), the memory-stage update port (up_*),
// the init status and the single-port table RAM port (mem_*).
//   slave  : view taken by bpred_table_sched
//   master : view taken by the surrounding pipeline / RAM
interface bpred_table_sched_if #(
    parameter int IDX_W = 10
);
    logic             lk_req;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_gnt;
    logic             lk_rvalid;
    logic [1:0]       lk_rdata;
    logic             up_valid;
    logic [IDX_W-1:0] up_idx;
    logic             up_taken;
    logic             up_ready;
    logic             init_busy;
    logic             mem_en;
    logic             mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [1:0]       mem_wdata;
    logic [1:0]       mem_rdata;

    modport slave (
        input  lk_req, lk_idx, up_valid, up_idx, up_taken, mem_rdata,
        output lk_gnt, lk_rvalid, lk_rdata, up_ready, init_busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output lk_req, lk_idx, up_valid, up_idx, up_taken, mem_rdata,
        input  lk_gnt, lk_rvalid, lk_rdata, up_ready, init_busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/bpred_upd_fifo.sv
// Synchronous FIFO holding pending predictor updates in arrival order.
// Ports: clk, rst (sync, active-high), push_i/wdata_i, pop_i, rdata_o (head),
// full_o, empty_o, count_o. DEPTH must be a power of two, >= 2, so the
// pointers wrap naturally.
module bpred_upd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rptr_q];
    assign do_pop_s  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push_s) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push_s && do_pop_s) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bpred_table_sched.sv
// Scheduler / port arbiter for the 2-bit branch pattern table held in an
// external single-port synchronous RAM.
//   - After reset sweeps every entry to INIT_VAL (init_busy high).
//   - Grants fetch lookups (lk_gnt combinational, lk_rvalid one cycle later,
//     lk_rdata straight from mem_rdata).
//   - Queues resolved-branch updates and retires them in order as a
//     read cycle followed by a write of the saturated counter.
// Ports: clk, rst (sync, active-high), bus (bpred_table_sched_if.slave).
module bpred_table_sched
    import bpred_pkg::*;
#(
    parameter int         IDX_W      = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_VAL   = 2'b10
) (
    input  logic                 clk,
    input  logic                 rst,
    bpred_table_sched_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = IDX_W + 1;

    sched_state_e     state_q;
    sched_state_e     cur_state_s;
    logic [IDX_W-1:0] sweep_q;
    logic [IDX_W-1:0] cur_sweep_s;
    logic             lk_rvalid_q;
    logic             issue_upd_s;
    logic             lk_gnt_s;
    logic             up_ready_s;
    logic             init_busy_s;
    logic             mem_en_s;
    logic             mem_we_s;
    logic [IDX_W-1:0] mem_addr_s;
    logic [1:0]       mem_wdata_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CW-1:0]    fifo_count_s;
    logic [EW-1:0]    head_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             head_taken_s;

    assign head_idx_s   = head_s[EW-1:1];
    assign head_taken_s = head_s[0];
    assign fifo_push_s  = bus.up_valid & up_ready_s;
    assign fifo_pop_s   = (state_q == S_UPD_WR);

    bpred_upd_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push_s),
        .wdata_i ({bus.up_idx, bus.up_taken}),
        .pop_i   (fifo_pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Port arbitration. While rst is high the outputs already show the
    // first sweep cycle, so a half-finished read-modify-write never writes.
    always_comb begin
        cur_state_s = rst ? S_INIT : state_q;
        cur_sweep_s = rst ? '0 : sweep_q;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = 2'b00;
        lk_gnt_s    = 1'b0;
        issue_upd_s = 1'b0;
        case (cur_state_s)
            S_INIT: begin
                mem_en_s    = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = cur_sweep_s;
                mem_wdata_s = INIT_VAL;
            end
            S_RUN: begin
                // Updates yield to lookups until the queue is full.
                if (fifo_full_s || (!fifo_empty_s && !bus.lk_req)) begin
                    issue_upd_s = 1'b1;
                    mem_en_s    = 1'b1;
                    mem_addr_s  = head_idx_s;
                end else if (bus.lk_req) begin
                    lk_gnt_s    = 1'b1;
                    mem_en_s    = 1'b1;
                    mem_addr_s  = bus.lk_idx;
                end else begin
                    mem_en_s    = 1'b0;
                end
            end
            S_UPD_WR: begin
                mem_en_s    = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = head_idx_s;
                mem_wdata_s = sat(bus.mem_rdata, head_taken_s);
            end
            default: begin
                mem_en_s    = 1'b0;
            end
        endcase
        init_busy_s = (cur_state_s == S_INIT);
        up_ready_s  = !init_busy_s && (fifo_count_s < CW'(FIFO_DEPTH));
    end

    // Scheduler FSM, sweep counter and lookup-valid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            sweep_q     <= '0;
            lk_rvalid_q <= 1'b0;
        end else begin
            lk_rvalid_q <= lk_gnt_s;
            case (state_q)
                S_INIT: begin
                    sweep_q <= sweep_q + IDX_W'(1);
                    if (sweep_q == '1) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue_upd_s) begin
                        state_q <= S_UPD_WR;
                    end
                end
                S_UPD_WR: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign bus.lk_gnt    = lk_gnt_s;
    assign bus.lk_rvalid = lk_rvalid_q;
    assign bus.lk_rdata  = bus.mem_rdata;
    assign bus.up_ready  = up_ready_s;
    assign bus.init_busy = init_busy_s;
    assign bus.mem_en    = mem_en_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_bpred_table_sched.sv
// Self-checking bench for bpred_table_sched (IDX_W=4, FIFO_DEPTH=4).
// A behavioural model (update queue, per-entry table values, init countdown)
// predicts every cycle's port activity; a simple RAM model answers reads.
module tb_bpred_table_sched;
    localparam int N     = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0] idx;
        logic [1:0] wval;
    } upd_t;

    logic clk;
    logic rst;
    logic [1:0] ram [N];
    logic [1:0] rd_q;

    upd_t       mq[$];
    int         init_left;
    bit         wr_pend;
    bit         prev_gnt;
    bit         last_acc;
    bit         rd_known;
    logic [1:0] rd_exp;
    int         ref_tab [N];
    int         n_chk;
    int         n_pass;

    bpred_table_sched_if #(.IDX_W(4)) bus ();

    bpred_table_sched #(
        .IDX_W      (4),
        .FIFO_DEPTH (DEPTH),
        .INIT_VAL   (2'b10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM holding the pattern table.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) rd_q <= ram[bus.mem_addr];
    end
    assign bus.mem_rdata = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock cycle: predict, compare mid-cycle, then advance the model.
    task automatic cycle();
        bit e_en, e_we, e_gnt, e_ready, e_busy, issue;
        logic [3:0] e_addr;
        logic [1:0] e_wdata;
        int v;
        int pend;
        @(negedge clk);
        e_en = 1'b0; e_we = 1'b0; e_gnt = 1'b0; issue = 1'b0;
        e_addr = 4'd0; e_wdata = 2'b00;
        e_busy = rst || (init_left > 0);
        if (e_busy) begin
            e_en = 1'b1; e_we = 1'b1; e_wdata = 2'b10;
            e_addr = rst ? 4'd0 : 4'(N - init_left);
        end else if (wr_pend) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = mq[0].idx; e_wdata = mq[0].wval;
        end else if (mq.size() == DEPTH || (mq.size() > 0 && !bus.lk_req)) begin
            e_en = 1'b1; e_addr = mq[0].idx; issue = 1'b1;
        end else if (bus.lk_req) begin
            e_en = 1'b1; e_gnt = 1'b1; e_addr = bus.lk_idx;
        end
        e_ready = !e_busy && (mq.size() < DEPTH);

        chk("init_busy", 32'(bus.init_busy), 32'(e_busy));
        chk("lk_gnt", 32'(bus.lk_gnt), 32'(e_gnt));
        chk("up_ready", 32'(bus.up_ready), 32'(e_ready));
        chk("lk_rvalid", 32'(bus.lk_rvalid), 32'(prev_gnt));
        chk("mem_en", 32'(bus.mem_en), 32'(e_en));
        if (e_en) begin
            chk("mem_we", 32'(bus.mem_we), 32'(e_we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        end
        if (e_en && e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        if (prev_gnt && rd_known) chk("lk_rdata", 32'(bus.lk_rdata), 32'(rd_exp));

        // Lookup data is predictable when no queued update targets the entry.
        rd_known = 1'b0;
        if (e_gnt) begin
            pend = 0;
            foreach (mq[i]) if (mq[i].idx == bus.lk_idx) pend++;
            rd_known = (pend == 0);
            rd_exp = 2'(ref_tab[bus.lk_idx]);
        end

        last_acc = bus.up_valid && e_ready;
        if (rst) begin
            mq.delete();
            wr_pend = 1'b0;
            init_left = N;
            for (int i = 0; i < N; i++) ref_tab[i] = 2;
        end else begin
            if (init_left > 0) init_left--;
            else if (wr_pend) begin
                void'(mq.pop_front());
                wr_pend = 1'b0;
            end else if (issue) wr_pend = 1'b1;
            if (last_acc) begin
                v = ref_tab[bus.up_idx];
                v = bus.up_taken ? ((v + 1 > 3) ? 3 : v + 1) : ((v - 1 < 0) ? 0 : v - 1);
                ref_tab[bus.up_idx] = v;
                mq.push_back('{idx: bus.up_idx, wval: 2'(v)});
            end
        end
        prev_gnt = e_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic enq(input logic [3:0] idx, input logic taken);
        bus.up_valid = 1'b1; bus.up_idx = idx; bus.up_taken = taken;
        cycle();
        bus.up_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        init_left = N; wr_pend = 1'b0; prev_gnt = 1'b0; rd_known = 1'b0; last_acc = 1'b0;
        rd_exp = 2'b00;
        for (int i = 0; i < N; i++) ref_tab[i] = 2;
        rst = 1'b1;
        bus.lk_req = 1'b0; bus.lk_idx = 4'd0;
        bus.up_valid = 1'b0; bus.up_idx = 4'd0; bus.up_taken = 1'b0;
        @(posedge clk);
        #1;
        idle(3);                       // reset values
        rst = 1'b0;
        idle(N + 2);                   // full sweep, then up_ready rises
        idle(2);

        enq(4'd5, 1'b1); idle(3);      // read one cycle after enqueue, write 2'b11
        enq(4'd3, 1'b1); idle(3);      // 2'b10 -> 2'b11
        enq(4'd3, 1'b1); enq(4'd3, 1'b1); idle(5);   // saturate at 2'b11
        enq(4'd0, 1'b0); enq(4'd0, 1'b0); idle(4);   // reach 2'b00
        enq(4'd0, 1'b0); idle(3);      // saturate at 2'b00
        enq(4'd7, 1'b1); enq(4'd7, 1'b0); idle(5);   // 2'b11 then 2'b10

        // Continuous lookups while the queue fills: forced retirement.
        bus.lk_req = 1'b1; bus.lk_idx = 4'd5;
        for (int i = 0; i < 4; i++) enq(4'(8 + i), 1'(i % 2));
        idle(12);
        bus.lk_req = 1'b0;
        idle(3);

        // Randomised traffic with protocol-respecting hold behaviour.
        for (int c = 0; c < 400; c++) begin
            if (!bus.lk_req || prev_gnt) begin
                bus.lk_req = ($urandom_range(0, 9) < 6);
                bus.lk_idx = 4'($urandom_range(0, 7));
            end
            if (!bus.up_valid || last_acc) begin
                bus.up_valid = ($urandom_range(0, 9) < 4);
                bus.up_idx = 4'($urandom_range(0, 7));
                bus.up_taken = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        bus.lk_req = 1'b0; bus.up_valid = 1'b0;
        idle(10);

        // Reset during the write half of a read-modify-write.
        enq(4'd9, 1'b1);
        for (int i = 0; i < 5 && !wr_pend; i++) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        idle(N + 4);

        // Reset in the middle of the sweep, at address 9.
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < N && init_left != N - 9; i++) cycle();
        rst = 1'b1; idle(2); rst = 1'b0;
        idle(N + 2);

        // Every entry should read back as weakly taken.
        for (int i = 0; i < N; i++) begin
            bus.lk_req = 1'b1; bus.lk_idx = 4'(i);
            cycle();
        end
        bus.lk_req = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bpred_table_sched.md
# bpred_table_sched

Scheduler and port arbiter for the branch predictor's 2-bit pattern table, which is held in an external single-port synchronous RAM. It does three jobs: it sweeps the whole table to the weakly-taken value after reset, it grants fetch-stage lookups, and it queues resolved-branch updates from the memory stage and retires them as two-cycle read-modify-write sequences. It sits between the fetch/decode prediction logic and the table RAM.

## Interface
- IDX_W, 10, table index width; the table holds 2^IDX_W entries.
- FIFO_DEPTH, 4, update queue depth; must be a power of two and at least 2.
- INIT_VAL, 2'b10, counter value written during the init sweep (weakly taken).

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- lk_req  in  1  fetch-stage lookup request
- lk_idx  in  IDX_W  lookup index
- lk_gnt  out  1  lookup granted this cycle (combinational)
- lk_rvalid  out  1  lookup data valid; registered copy of lk_gnt
- lk_rdata  out  2  lookup counter value; equals mem_rdata
- up_valid  in  1  resolved-branch update offered
- up_idx  in  IDX_W  update index
- up_taken  in  1  actual branch outcome
- up_ready  out  1  update accepted when up_valid & up_ready
- init_busy  out  1  init sweep in progress
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  IDX_W  RAM address
- mem_wdata  out  2  RAM write data
- mem_rdata  in  2  RAM read data; valid one cycle after a read with mem_en=1, mem_we=0

## Operation
- States: INIT, RUN, UPD_WR.
- INIT:
  - Each cycle: mem_en=1, mem_we=1, mem_addr=sweep counter, mem_wdata=INIT_VAL, then the counter increments.
  - After the write to address 2^IDX_W-1, go to RUN.
  - init_busy=1, lk_gnt=0, up_ready=0.
- RUN, arbitration evaluated every cycle in this priority order:
  1. Queue full, or (queue non-empty and lk_req=0): issue an update read. mem_en=1, mem_we=0, mem_addr=head.idx, lk_gnt=0. Go to UPD_WR.
  2. Otherwise, if lk_req=1: lk_gnt=1, mem_en=1, mem_we=0, mem_addr=lk_idx.
  3. Otherwise: mem_en=0.
- UPD_WR (one cycle):
  - mem_en=1, mem_we=1, mem_addr=head.idx, mem_wdata=sat(mem_rdata, head.taken).
  - Pop the head; lk_gnt=0; return to RUN.
- sat() is a 2-bit saturating counter:
  - taken: min(v+1, 3)
  - not taken: max(v-1, 0)
- Update queue:
  - Synchronous FIFO with entries {idx, taken}.
  - up_ready = !init_busy & (count < FIFO_DEPTH).
  - Push and pop may occur in the same cycle. Count only changes on a push without a pop, or a pop without a push.
- Updates retire strictly in order, one at a time. A later update to the same index therefore always reads the earlier update's written value.
- Lookups do not bypass queued updates. A lookup may return a value that predates pending updates to its index; this is architecturally permitted.
- Flush of the decode/execute stages has no effect here. Queued updates come from committed memory-stage branches and always retire.

## Timing
- Reset values:
  - State INIT, sweep counter 0, queue empty.
  - init_busy=1, lk_gnt=0, lk_rvalid=0, up_ready=0.
  - mem_en=1, mem_we=1, mem_addr=0 (the sweep begins in the first cycle after rst deasserts).
- Init length:
  - The sweep lasts exactly 2^IDX_W cycles.
  - init_busy falls in the cycle after the last sweep write.
- Lookup latency:
  - lk_gnt is in the request cycle; lk_rvalid and lk_rdata follow one cycle later.
  - Requesters hold lk_req and lk_idx until lk_gnt=1.
- Update cost:
  - Each update takes two cycles of the port, during which lk_gnt=0.
  - Minimum enqueue-to-write latency is two cycles on an idle port.
- Lookup starvation bound:
  - A denied lookup waits at most 2 cycles per queued entry.
  - While the queue is not full, continuous lk_req holds off updates indefinitely; a full queue forces retirement.
- rst asserted in any state, including INIT and UPD_WR:
  - Discards the queue and any half-finished read-modify-write.
  - Restarts the sweep at address 0 in the next cycle.

## Structure
- Shared package bpred_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - the state enum
  - the sat() function
- Sub-module bpred_upd_fifo: a parameterised synchronous FIFO with push, pop, full, empty and count.
- The arbiter FSM lives in bpred_table_sched.

## Test plan
- IDX_W=4, release rst: 16 consecutive writes of 2'b10 to addresses 0..15; init_busy falls on cycle 16; up_ready then rises.
- Idle port, single update idx=5 taken on a 2'b10 entry: read of 5 one cycle after enqueue, then write of 2'b11; queue empties.
- Saturation:
  - Two taken updates on idx=3 starting at 2'b11 both write 2'b11.
  - Not-taken on an entry at 2'b00 writes 2'b00.
- Continuous lk_req with 4 updates enqueued:
  - up_ready drops at count=4.
  - lk_gnt drops and the read-modify-write sequences proceed, each costing 2 lookup cycles.
  - Lookups resume once the queue is no longer full.
- Same idx=7 updates back-to-back (taken, then not-taken) from 2'b10: writes 2'b11, then 2'b10.
- rst asserted mid-sweep at address 9, and again during UPD_WR: the queue empties, no stale write is issued, and the sweep restarts at 0.
